// File: rtl/pc_pkg.sv
// ============================================================================
//  Module      : pc_pkg
//  Description : Shared constants for the program-counter sequencer:
//                next-PC select encodings and default vectors.
//                Optional feature macro: PC_TRAP_EN (trap entry / ERET).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_pkg;

    // Next-PC select encodings driven by the control unit
    localparam logic [3:0] PC_SEQ    = 4'b0000;
    localparam logic [3:0] PC_JUMP   = 4'b0001;
    localparam logic [3:0] PC_JR     = 4'b0010;
    localparam logic [3:0] PC_BRANCH = 4'b0011;
    localparam logic [3:0] PC_CALL   = 4'b0100;
    localparam logic [3:0] PC_JALR   = 4'b0101;
    localparam logic [3:0] PC_RET    = 4'b0110;
    localparam logic [3:0] PC_ERET   = 4'b0111;

    // Default vectors, wide enough for the largest legal ADDR_W
    localparam logic [63:0] PC_DEFAULT_RESET_VECTOR = 64'h0;
    localparam logic [63:0] PC_DEFAULT_TRAP_VECTOR  = 64'h80;

endpackage

`default_nettype wire

// File: rtl/ras_stack.sv
// ============================================================================
//  Module      : ras_stack
//  Description : Circular return-address stack. A push when full overwrites
//                the oldest entry; a pop when empty leaves the stack alone.
//                Overflow/underflow are registered one-cycle pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ras_stack #(
    parameter int ADDR_W    = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [ADDR_W-1:0]            push_data_i,
    output logic [ADDR_W-1:0]            top_o,
    output logic [$clog2(RAS_DEPTH):0]   count_o,
    output logic                         overflow_o,
    output logic                         underflow_o
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(RAS_DEPTH);

    logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  top_ptr;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    // wr_ptr is the next free slot; the newest entry sits just below it
    assign top_ptr = wr_ptr_q - PTR_W'(1);

    // Pointer/count update; a full push wraps and keeps the count saturated
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (count_q == FULL) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (pop_i) begin
            if (count_q == '0) begin
                underflow_d = 1'b1;
            end else begin
                wr_ptr_d = top_ptr;
                count_d  = count_q - CNT_W'(1);
            end
        end
    end

    // Control state register; reset empties the stack logically
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Entry storage; contents beyond count are don't-care so no reset
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign top_o       = mem_q[top_ptr];
    assign count_o     = count_q;
    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
//  Module      : pc_sequencer
//  Description : Fetch PC register and next-PC selection (seq, jump, JR,
//                branch, call/JALR/return via return-address stack, stall).
//                Optional feature macro: PC_TRAP_EN adds trap input, epc
//                output and the ERET select code.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer
    import pc_pkg::*;
#(
    parameter int              ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(PC_DEFAULT_RESET_VECTOR),
    parameter int              RAS_DEPTH    = 4,
    parameter logic [ADDR_W-1:0] TRAP_VECTOR  = ADDR_W'(PC_DEFAULT_TRAP_VECTOR)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         stall,
    input  logic [3:0]                   pc_control,
    input  logic                         branch_taken,
    input  logic [25:0]                  jump_address,
    input  logic [15:0]                  branch_offset,
    input  logic [ADDR_W-1:0]            reg_address,
`ifdef PC_TRAP_EN
    input  logic                         trap,
    output logic [ADDR_W-1:0]            epc,
`endif
    output logic [ADDR_W-1:0]            pc,
    output logic [ADDR_W-1:0]            pc_plus4,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_overflow,
    output logic                         ras_underflow
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] jump_target;
    logic [ADDR_W-1:0] branch_disp;
    logic [ADDR_W-1:0] branch_target;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_push, ras_pop;
`ifdef PC_TRAP_EN
    logic [ADDR_W-1:0] epc_q, epc_d;
`endif

    // J-type target keeps the PC's upper region; at ADDR_W=28 there is none
    generate
        if (ADDR_W > 28) begin : g_jump_region
            assign jump_target = {pc_q[ADDR_W-1:28], jump_address, 2'b00};
        end else begin : g_jump_full
            assign jump_target = {jump_address, 2'b00};
        end
    endgenerate

    assign pc_plus4      = pc_q + ADDR_W'(4);
    assign branch_disp   = {{(ADDR_W-18){branch_offset[15]}}, branch_offset, 2'b00};
    assign branch_target = pc_plus4 + branch_disp;

    // Next-PC select and RAS requests; trap beats stall, stall beats control
    always_comb begin
        pc_d     = pc_q;
        ras_push = 1'b0;
        ras_pop  = 1'b0;
`ifdef PC_TRAP_EN
        epc_d    = epc_q;
        if (trap) begin
            epc_d = pc_q;
            pc_d  = TRAP_VECTOR;
        end else if (!stall) begin
`else
        if (!stall) begin
`endif
            case (pc_control)
                PC_SEQ:    pc_d = pc_plus4;
                PC_JUMP:   pc_d = jump_target;
                PC_JR:     pc_d = reg_address;
                PC_BRANCH: pc_d = branch_taken ? branch_target : pc_plus4;
                PC_CALL: begin
                    pc_d     = jump_target;
                    ras_push = 1'b1;
                end
                PC_JALR: begin
                    pc_d     = reg_address;
                    ras_push = 1'b1;
                end
                PC_RET: begin
                    ras_pop = 1'b1;
                    pc_d    = (ras_count != '0) ? ras_top : reg_address;
                end
`ifdef PC_TRAP_EN
                PC_ERET:   pc_d = epc_q;
`endif
                default:   pc_d = pc_q;
            endcase
        end
    end

    // PC (and exception PC) register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q  <= RESET_VECTOR;
`ifdef PC_TRAP_EN
            epc_q <= '0;
`endif
        end else begin
            pc_q  <= pc_d;
`ifdef PC_TRAP_EN
            epc_q <= epc_d;
`endif
        end
    end

    ras_stack #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (ras_push),
        .pop_i       (ras_pop),
        .push_data_i (pc_plus4),
        .top_o       (ras_top),
        .count_o     (ras_count),
        .overflow_o  (ras_overflow),
        .underflow_o (ras_underflow)
    );

    assign pc = pc_q;
`ifdef PC_TRAP_EN
    assign epc = epc_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
//  Module      : tb_pc_sequencer
//  Description : Directed self-checking bench for pc_sequencer with a
//                queue-based reference model feeding a scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic [3:0]  pc_control;
    logic        branch_taken;
    logic [25:0] jump_address;
    logic [15:0] branch_offset;
    logic [31:0] reg_address;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [2:0]  ras_count;
    logic        ras_overflow;
    logic        ras_underflow;
`ifdef PC_TRAP_EN
    logic        trap;
    logic [31:0] epc;
`endif

    pc_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .pc_control    (pc_control),
        .branch_taken  (branch_taken),
        .jump_address  (jump_address),
        .branch_offset (branch_offset),
        .reg_address   (reg_address),
`ifdef PC_TRAP_EN
        .trap          (trap),
        .epc           (epc),
`endif
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .ras_count     (ras_count),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] cnt;
        logic        ov;
        logic        un;
        logic [31:0] epc;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;

    // Reference model state: RAS as a plain queue, newest at the back
    logic [31:0] m_pc;
    logic [31:0] m_epc;
    logic [31:0] m_ras[$];
    logic        m_ov, m_un;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic m_push(input logic [31:0] link);
        m_ras.push_back(link);
        if (m_ras.size() > 4) begin
            void'(m_ras.pop_front());
            m_ov = 1'b1;
        end
    endtask

    task automatic model(input logic rst, input logic stl, input logic [3:0] ctl,
                         input logic tkn, input logic [25:0] ja, input logic [15:0] off,
                         input logic [31:0] ra, input logic trp);
        logic [31:0] nxt;
        logic [31:0] jt;
        nxt = m_pc + 32'd4;
        jt  = {m_pc[31:28], ja, 2'b00};
        m_ov = 1'b0;
        m_un = 1'b0;
        if (!rst) begin
            m_pc  = 32'h0;
            m_epc = 32'h0;
            m_ras.delete();
        end else if (trp) begin
            m_epc = m_pc;
            m_pc  = 32'h80;
        end else if (!stl) begin
            case (ctl)
                4'd0: m_pc = nxt;
                4'd1: m_pc = jt;
                4'd2: m_pc = ra;
                4'd3: m_pc = tkn ? nxt + {{14{off[15]}}, off, 2'b00} : nxt;
                4'd4: begin m_push(nxt); m_pc = jt; end
                4'd5: begin m_push(nxt); m_pc = ra; end
                4'd6: begin
                    if (m_ras.size() > 0) m_pc = m_ras.pop_back();
                    else begin m_pc = ra; m_un = 1'b1; end
                end
`ifdef PC_TRAP_EN
                4'd7: m_pc = m_epc;
`endif
                default: ;
            endcase
        end
    endtask

    // Drive one cycle of stimulus, predict, then compare after the edge
    task automatic step(input string tag, input logic rst, input logic stl, input logic [3:0] ctl,
                        input logic tkn, input logic [25:0] ja, input logic [15:0] off,
                        input logic [31:0] ra, input logic trp);
        exp_t e;
        rst_n = rst; stall = stl; pc_control = ctl; branch_taken = tkn;
        jump_address = ja; branch_offset = off; reg_address = ra;
`ifdef PC_TRAP_EN
        trap = trp;
`endif
        model(rst, stl, ctl, tkn, ja, off, ra, trp);
        e.pc = m_pc; e.cnt = m_ras.size(); e.ov = m_ov; e.un = m_un; e.epc = m_epc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".pc"},       pc,                  e.pc);
        chk({tag, ".pc_plus4"}, pc_plus4,            e.pc + 32'd4);
        chk({tag, ".count"},    {29'd0, ras_count},  e.cnt);
        chk({tag, ".ovf"},      {31'd0, ras_overflow},  {31'd0, e.ov});
        chk({tag, ".udf"},      {31'd0, ras_underflow}, {31'd0, e.un});
`ifdef PC_TRAP_EN
        chk({tag, ".epc"},      epc,                 e.epc);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        m_pc = 32'h0; m_epc = 32'h0; m_ov = 1'b0; m_un = 1'b0;
        // Reset and sequential fetch
        step("reset",   0, 0, 4'd0, 0, 26'h0, 16'h0, 32'h0, 0);
        step("seq1",    1, 0, 4'd0, 0, 26'h0, 16'h0, 32'h0, 0);
        step("seq2",    1, 0, 4'd0, 1, 26'h0, 16'h7, 32'h0, 0);
        step("seq3",    1, 0, 4'd0, 0, 26'h0, 16'h0, 32'h0, 0);
        chk("seq_c", pc, 32'hC);
        step("rst_mid", 0, 0, 4'd0, 0, 26'h0, 16'h0, 32'h0, 0);
        chk("rst_zero", pc, 32'h0);
        // Jumps and branches
        step("jump",    1, 0, 4'd1, 0, 26'h3FF_FFFF, 16'h0, 32'h0, 0);
        step("jr100",   1, 0, 4'd2, 0, 26'h0, 16'h0, 32'h100, 0);
        step("br_back", 1, 0, 4'd3, 1, 26'h0, 16'hFFFF, 32'h0, 0);
        chk("br_self", pc, 32'h100);
        step("br_nt",   1, 0, 4'd3, 0, 26'h0, 16'hFFFF, 32'h0, 0);
        chk("br_nt_val", pc, 32'h104);
        step("br_fwd",  1, 0, 4'd3, 1, 26'h0, 16'h0010, 32'h0, 0);
        step("jr_top",  1, 0, 4'd2, 0, 26'h0, 16'h0, 32'hFFFF_FFFC, 0);
        step("wrap",    1, 0, 4'd0, 0, 26'h0, 16'h0, 32'h0, 0);
        chk("wrap_zero", pc, 32'h0);
        step("unused",  1, 0, 4'd9, 1, 26'h0, 16'h0, 32'h5555, 0);
        step("code7",   1, 0, 4'd7, 0, 26'h0, 16'h0, 32'h5555, 0);
        // Single call/return
        step("jr_c",    1, 0, 4'd2, 0, 26'h0, 16'h0, 32'h1000_0040, 0);
        step("call",    1, 0, 4'd4, 0, 26'h40, 16'h0, 32'h0, 0);
        chk("call_pc", pc, 32'h1000_0100);
        step("ret",     1, 0, 4'd6, 0, 26'h0, 16'h0, 32'hDEAD_BEE0, 0);
        chk("ret_pc", pc, 32'h1000_0044);
        // Nested calls: overflow on fifth push, LIFO drain, then underflow
        step("call_a",  1, 0, 4'd4, 0, 26'h100, 16'h0, 32'h0, 0);
        step("jalr_b",  1, 0, 4'd5, 0, 26'h0, 16'h0, 32'h0000_2003, 0);
        step("call_c",  1, 0, 4'd4, 0, 26'h300, 16'h0, 32'h0, 0);
        step("call_d",  1, 0, 4'd4, 0, 26'h400, 16'h0, 32'h0, 0);
        step("call_e",  1, 0, 4'd4, 0, 26'h500, 16'h0, 32'h0, 0);
        chk("ovf_pulse", {31'd0, ras_overflow}, 32'd1);
        step("ret1",    1, 0, 4'd6, 0, 26'h0, 16'h0, 32'h0, 0);
        step("ret2",    1, 0, 4'd6, 0, 26'h0, 16'h0, 32'h0, 0);
        step("ret3",    1, 0, 4'd6, 0, 26'h0, 16'h0, 32'h0, 0);
        step("ret4",    1, 0, 4'd6, 0, 26'h0, 16'h0, 32'h0, 0);
        step("ret5",    1, 0, 4'd6, 0, 26'h0, 16'h0, 32'h1234_5678, 0);
        chk("udf_pc", pc, 32'h1234_5678);
        // Stalled call executes once after release
        step("stall1",  1, 1, 4'd4, 0, 26'h80, 16'h0, 32'h0, 0);
        step("stall2",  1, 1, 4'd4, 1, 26'h80, 16'h0, 32'h0, 0);
        step("stall3",  1, 1, 4'd6, 0, 26'h80, 16'h0, 32'h0, 0);
        step("release", 1, 0, 4'd4, 0, 26'h80, 16'h0, 32'h0, 0);
        step("after",   1, 0, 4'd0, 0, 26'h0, 16'h0, 32'h0, 0);
        // Reset mid call sequence discards the stack
        step("jalr_x",  1, 0, 4'd5, 0, 26'h0, 16'h0, 32'h0000_3000, 0);
        step("rst_ras", 0, 0, 4'd4, 0, 26'h10, 16'h0, 32'h0, 0);
        step("ret_emp", 1, 0, 4'd6, 0, 26'h0, 16'h0, 32'h0000_0ABC, 0);
`ifdef PC_TRAP_EN
        step("jr200",   1, 0, 4'd2, 0, 26'h0, 16'h0, 32'h200, 0);
        step("trap",    1, 1, 4'd4, 0, 26'h10, 16'h0, 32'h0, 1);
        chk("trap_pc", pc, 32'h80);
        chk("trap_epc", epc, 32'h200);
        step("eret",    1, 0, 4'd7, 0, 26'h0, 16'h0, 32'h0, 0);
        chk("eret_pc", pc, 32'h200);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
